// File: rtl/fp_pkg.sv
// Shared definitions for the FP subtraction datapath: widths, result field
// layout, the normalizer state encoding and the result packing helper.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 24;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam int RES_SIGN   = 31;
    localparam int RES_EXP_HI = 30;
    localparam int RES_EXP_LO = 23;
    localparam int RES_MAN_HI = 22;
    localparam int RES_MAN_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [31:0] pack_result(input logic       s,
                                                input logic [7:0]  e,
                                                input logic [22:0] m);
        logic [31:0] r;
        r                         = '0;
        r[RES_SIGN]               = s;
        r[RES_EXP_HI:RES_EXP_LO]  = e;
        r[RES_MAN_HI:RES_MAN_LO]  = m;
        return r;
    endfunction

endpackage

// File: rtl/fp_mag_sub.sv
// Combinational effective add/subtract of two aligned mantissas. Produces the
// result magnitude (already shifted right on carry), its sign and the carry.
module fp_mag_sub #(
    parameter int MAN_W = 24
) (
    input  logic [MAN_W-1:0] i_man_a,
    input  logic [MAN_W-1:0] i_man_b,
    input  logic             i_sign_a,
    input  logic             i_sign_b,
    output logic [MAN_W-1:0] o_mag,
    output logic             o_sign,
    output logic             o_carry,
    output logic             o_eff_add
);

    logic [MAN_W:0]   w_sum;
    logic [MAN_W-1:0] w_diff;
    logic             w_a_ge_b;

    // A - B with opposite signs is a magnitude addition
    assign o_eff_add = i_sign_a ^ i_sign_b;
    assign w_sum     = {1'b0, i_man_a} + {1'b0, i_man_b};
    assign w_a_ge_b  = (i_man_a >= i_man_b);
    assign w_diff    = w_a_ge_b ? (i_man_a - i_man_b) : (i_man_b - i_man_a);

    always_comb begin
        o_mag   = w_diff;
        o_sign  = w_a_ge_b ? i_sign_a : ~i_sign_a;
        o_carry = 1'b0;
        if (o_eff_add) begin
            o_sign  = i_sign_a;
            o_carry = w_sum[MAN_W];
            o_mag   = w_sum[MAN_W] ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
        end
    end

endmodule

// File: rtl/fp_sub_normalize.sv
// Mantissa subtract and iterative left-shift normalizer (one shift per cycle)
// producing a packed single-precision result with zero/overflow/underflow flags.
module fp_sub_normalize #(
    parameter int MAN_W = fp_pkg::MAN_W,
    parameter int EXP_W = fp_pkg::EXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [MAN_W-1:0] man_a,
    input  logic [MAN_W-1:0] man_b,
    input  logic             sign_a,
    input  logic             sign_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             zero,
    output logic             overflow,
    output logic             underflow
);
    import fp_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [EXP_W-1:0] r_exp;
    logic [MAN_W-1:0] r_man_a;
    logic [MAN_W-1:0] r_man_b;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [MAN_W-1:0] r_mag;
    logic             r_sign;
    logic [31:0]      r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_underflow;

    logic [MAN_W-1:0] w_calc_mag;
    logic             w_calc_sign;
    logic             w_carry;
    logic             w_eff_add;
    logic [EXP_W:0]   w_exp_inc;
    logic             w_exp_ovf;
    logic [MAN_W-1:0] w_shift_mag;
    logic [EXP_W-1:0] w_exp_dec;
    logic             w_flush;

    fp_mag_sub #(.MAN_W(MAN_W)) u_mag_sub (
        .i_man_a   (r_man_a),
        .i_man_b   (r_man_b),
        .i_sign_a  (r_sign_a),
        .i_sign_b  (r_sign_b),
        .o_mag     (w_calc_mag),
        .o_sign    (w_calc_sign),
        .o_carry   (w_carry),
        .o_eff_add (w_eff_add)
    );

    // Exponent kept one bit wider so an increment past the max is still caught
    assign w_exp_inc   = {1'b0, r_exp} + {{EXP_W{1'b0}}, w_carry};
    assign w_exp_ovf   = (w_exp_inc >= {1'b0, EXP_MAX});
    assign w_shift_mag = {r_mag[MAN_W-2:0], 1'b0};
    assign w_exp_dec   = r_exp - EXP_W'(1);
    assign w_flush     = (r_exp <= EXP_W'(1));

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (in_valid) w_state_nxt = CALC;
            CALC: begin
                if (w_eff_add || (w_calc_mag == '0) || w_calc_mag[MAN_W-1])
                    w_state_nxt = DONE;
                else
                    w_state_nxt = NORM;
            end
            NORM: if (w_flush || w_shift_mag[MAN_W-1]) w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_exp       <= exp_in;
                        r_man_a     <= man_a;
                        r_man_b     <= man_b;
                        r_sign_a    <= sign_a;
                        r_sign_b    <= sign_b;
                        r_zero      <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                    end
                end
                CALC: begin
                    r_mag  <= w_calc_mag;
                    r_sign <= w_calc_sign;
                    if (w_eff_add) begin
                        if (w_exp_ovf) begin
                            r_result   <= pack_result(w_calc_sign, EXP_MAX, 23'h0);
                            r_overflow <= 1'b1;
                        end else begin
                            r_result <= pack_result(w_calc_sign, w_exp_inc[EXP_W-1:0],
                                                    w_calc_mag[MAN_W-2:0]);
                        end
                    end else if (w_calc_mag == '0) begin
                        // Exact cancellation always yields +0
                        r_result <= '0;
                        r_zero   <= 1'b1;
                    end else if (w_calc_mag[MAN_W-1]) begin
                        r_result <= pack_result(w_calc_sign, r_exp, w_calc_mag[MAN_W-2:0]);
                    end
                end
                NORM: begin
                    if (w_flush) begin
                        r_result    <= pack_result(r_sign, 8'h0, 23'h0);
                        r_zero      <= 1'b1;
                        r_underflow <= 1'b1;
                    end else begin
                        r_mag <= w_shift_mag;
                        r_exp <= w_exp_dec;
                        if (w_shift_mag[MAN_W-1])
                            r_result <= pack_result(r_sign, w_exp_dec, w_shift_mag[MAN_W-2:0]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sub_normalize.sv
// Table-driven scoreboard bench for fp_sub_normalize plus backpressure and
// mid-operation reset sequences.
module tb_fp_sub_normalize;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp_in;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic        sign_a;
    logic        sign_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]  e;
        logic [23:0] ma;
        logic [23:0] mb;
        logic        sa;
        logic        sb;
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        uf;
        int          lat;
    } vec_t;

    vec_t vecs[12];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    fp_sub_normalize dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_in    (exp_in),
        .man_a     (man_a),
        .man_b     (man_b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_before_drive", {31'h0, in_ready}, 32'h1);
        exp_in   = v.e;
        man_a    = v.ma;
        man_b    = v.mb;
        sign_a   = v.sa;
        sign_b   = v.sb;
        in_valid = 1'b1;
        sb_q.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        int   lat = 1;
        vec_t e;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h1);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_scoreboard: got empty queue, expected pending entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_result"},    result, e.res);
            check({tag, "_zero"},      {31'h0, zero}, {31'h0, e.z});
            check({tag, "_overflow"},  {31'h0, overflow}, {31'h0, e.ov});
            check({tag, "_underflow"}, {31'h0, underflow}, {31'h0, e.uf});
            check({tag, "_latency"},   lat, e.lat);
            check({tag, "_in_ready"},  {31'h0, in_ready}, 32'h0);
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_ready_back"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'd128, 24'hC00000, 24'h400000, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 2};
        vecs[1]  = '{8'd127, 24'h800000, 24'h800000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 2};
        vecs[2]  = '{8'd127, 24'h800000, 24'h600000, 1'b0, 1'b0, 32'h3E800000, 1'b0, 1'b0, 1'b0, 4};
        vecs[3]  = '{8'd128, 24'h400000, 24'h800000, 1'b0, 1'b0, 32'hBF800000, 1'b0, 1'b0, 1'b0, 3};
        vecs[4]  = '{8'd254, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b0, 2};
        vecs[5]  = '{8'd127, 24'h800000, 24'h400000, 1'b0, 1'b1, 32'h3FC00000, 1'b0, 1'b0, 1'b0, 2};
        vecs[6]  = '{8'd127, 24'hC00000, 24'hC00000, 1'b0, 1'b1, 32'h40400000, 1'b0, 1'b0, 1'b0, 2};
        vecs[7]  = '{8'd127, 24'h800000, 24'h600000, 1'b1, 1'b1, 32'hBE800000, 1'b0, 1'b0, 1'b0, 4};
        vecs[8]  = '{8'd127, 24'h800000, 24'h7FFFFF, 1'b0, 1'b0, 32'h34000000, 1'b0, 1'b0, 1'b0, 25};
        vecs[9]  = '{8'd0,   24'h400000, 24'h100000, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1, 3};
        vecs[10] = '{8'd3,   24'h800000, 24'h7FFFFF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 5};
        vecs[11] = '{8'd100, 24'hA00000, 24'h200000, 1'b1, 1'b0, 32'hB2400000, 1'b0, 1'b0, 1'b0, 2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        exp_in = '0; man_a = '0; man_b = '0; sign_a = 1'b0; sign_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  {31'h0, in_ready}, 32'h1);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_result",    result, 32'h0);
        check("reset_flags",     {29'h0, zero, overflow, underflow}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            collect($sformatf("vec%0d", i));
            release_out($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while the consumer stalls
        drive(vecs[0]);
        collect("bp");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_result", c), result, 32'h40000000);
            check($sformatf("bp_hold%0d_valid", c), {31'h0, out_valid}, 32'h1);
            check($sformatf("bp_hold%0d_in_ready", c), {31'h0, in_ready}, 32'h0);
        end
        release_out("bp");

        // Reset while normalizing a long shift sequence
        drive(vecs[8]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("norm_busy", {31'h0, in_ready | out_valid}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        check("rst_norm_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_norm_in_ready",  {31'h0, in_ready}, 32'h1);
        check("rst_norm_result",    result, 32'h0);

        // Reset with a result pending in DONE
        drive(vecs[4]);
        collect("pend");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_done_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_done_result",    result, 32'h0);
        check("rst_done_overflow",  {31'h0, overflow}, 32'h0);

        // Recovery after reset
        drive(vecs[3]);
        collect("recover");
        release_out("recover");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_sub_normalize.md
Name: fp_sub_normalize

Overview:
Downstream stage of the FP subtraction datapath. It consumes the exponent-aligned operands produced by the alignment stage and computes A - B on the 24-bit mantissas, including the hidden bit. It normalizes the result iteratively, one left shift per cycle, and emits a packed IEEE-754 single-precision result with status flags. A valid/ready handshake is used on both sides. Shifted-out bits are truncated; there is no rounding.

Parameters:
MAN_W, 24, mantissa width including hidden bit
EXP_W, 8, exponent width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  aligned operands present
in_ready  output  1  block can accept operands
exp_in  input  EXP_W  common (larger) exponent from alignment
man_a  input  MAN_W  aligned mantissa of A
man_b  input  MAN_W  aligned mantissa of B
sign_a  input  1  sign of A
sign_b  input  1  sign of B
out_valid  output  1  result held and valid
out_ready  input  1  consumer accepts result
result  output  32  {sign, exp[7:0], man[22:0]}
zero  output  1  exact zero result
overflow  output  1  exponent saturated, result is infinity
underflow  output  1  result flushed to zero during normalization

Behaviour:
- Reset, on a synchronous rst=1 edge:
  - state goes to IDLE.
  - in_ready=1, out_valid=0.
  - result=0, and zero, overflow and underflow are all 0.
  - rst overrides any state, including CALC, NORM, and DONE with a pending result.
- States: IDLE, CALC, NORM, DONE. in_ready=1 only in IDLE.
- IDLE:
  - If in_valid=1, register exp_in, man_a, man_b, sign_a and sign_b, then go to CALC.
  - If in_valid=0, stay in IDLE.
- CALC (one cycle):
  - Effective add when sign_a != sign_b:
    - sum = man_a + man_b, 25 bits wide; sign = sign_a.
    - If sum[24]=1: mantissa = sum >> 1 and exp = exp + 1.
    - If the new exp = 255: result = {sign, 8'hFF, 23'h0}, overflow=1.
    - Go to DONE.
  - Effective subtract when sign_a == sign_b:
    - If man_a >= man_b: mag = man_a - man_b, sign = sign_a.
    - Otherwise: mag = man_b - man_a, sign = ~sign_a.
  - Zero handling:
    - If mag = 0: result = 32'h0 (positive zero), zero=1, go to DONE.
  - Normalization check:
    - If mag[23]=1, go to DONE.
    - Otherwise go to NORM.
- NORM (one cycle per shift):
  - If exp <= 1: flush. result = {sign, 31'h0}, underflow=1, zero=1, go to DONE.
  - Otherwise: mag = mag << 1 and exp = exp - 1.
  - If the new mag[23]=1, go to DONE.
- Maximum residency in NORM is 23 cycles.
- DONE:
  - out_valid=1; result and flags are held stable.
  - On out_ready=1, go to IDLE. out_valid drops on the next cycle.
  - While out_ready=0, stay in DONE indefinitely.
- Result packing: {sign, exp, mag[22:0]}. The hidden bit is dropped.
- Latency, from the accept edge to the first cycle with out_valid=1:
  - 2 cycles when no left shift is needed.
  - 2 + k cycles when k left shifts are needed.
- Throughput: one operation in flight at a time. No new input is accepted until the DONE handshake completes.
- Flags are cleared when a new operation is accepted.
- exp_in=0 (denormal inputs): the same rules apply. If normalization is required, the result flushes to zero.

Decomposition:
- Shared package fp_pkg:
  - EXP_W, MAN_W, EXP_MAX = 255.
  - Result field offsets (sign 31, exp 30:23, man 22:0).
  - State enum {IDLE, CALC, NORM, DONE}.
- One natural sub-module, fp_mag_sub: combinational effective add/subtract producing magnitude, sign and carry. The FSM and normalizer remain in fp_sub_normalize.

Test Plan:
- 3.0 - 1.0: exp_in=128, man_a=0xC00000, man_b=0x400000, signs 0/0. Expect result=0x40000000, flags 0, out_valid 2 cycles after accept.
- 1.0 - 1.0: exp_in=127, man_a=man_b=0x800000, signs 0/0. Expect result=0x00000000, zero=1.
- 1.0 - 0.75: exp_in=127, man_a=0x800000, man_b=0x600000. Expect two NORM shifts, result=0x3E800000 (0.25), out_valid 4 cycles after accept.
- 1.0 - 2.0: exp_in=128, man_a=0x400000, man_b=0x800000, signs 0/0. Expect result=0xBF800000 (-1.0).
- Overflow: exp_in=254, man_a=man_b=0xFFFFFF, sign_a=0, sign_b=1. Expect result=0x7F800000, overflow=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE. Expect result stable and in_ready=0.
  - In a separate run, assert rst during NORM. Expect IDLE on the next cycle with out_valid=0 and in_ready=1.
